// File: rtl/input_fifo_rx.sv
// input_fifo_rx: 4-entry receive FIFO with a DRTS/CTS upstream handshake and
// one-hot downstream read strobes. Data_out falls through from the head entry.
// Optional build macro FIFO_ERR_EN adds a sticky err output flagging illegal
// reads (read while empty, or more than one read strobe at once).
module input_fifo_rx #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4    // only 4 is supported: pointers are 2 bits
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] RX,
   input  logic                  DRTS,
   input  logic [4:0]            read_en,
   output logic                  CTS,
   output logic [DATA_WIDTH-1:0] Data_out,
   output logic                  empty,
   output logic                  full
`ifdef FIFO_ERR_EN
   ,
   output logic                  err
`endif
);

   // Handshake: the sender raises DRTS and holds RX stable until it sees CTS.
   // CTS is a one-cycle registered grant; a flit transfers on the rising edge
   // that ends a cycle with CTS=1 and DRTS=1. A grant is only issued from IDLE
   // while not full, so a granted write always has room. The FSM state is
   // directly visible on CTS (IDLE -> 0, GRANT -> 1).
   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t                state;
   state_t                state_nxt;

   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
   logic [1:0]            wr_ptr;
   logic [1:0]            rd_ptr;
   logic [2:0]            count;
   logic [2:0]            count_nxt;
   logic                  wr_fire;
   logic                  rd_fire;

   assign CTS      = (state == GRANT);
   assign empty    = (count == 3'd0);
   assign full     = (count == 3'(DEPTH));
   assign wr_fire  = CTS && DRTS;
   assign rd_fire  = (read_en != 5'd0) && !empty;
   assign Data_out = mem[rd_ptr];

   // Handshake state register; reset aborts any grant in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: grant when requested and not full, grant lasts one cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (DRTS && !full) state_nxt = GRANT;
         GRANT:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Storage array is not reset; contents only matter once written.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem[wr_ptr] <= RX;
      end
   end

   // Occupancy change for write-only, read-only, or both/neither.
   always_comb begin
      count_nxt = count;
      case ({wr_fire, rd_fire})
         2'b10:   count_nxt = count + 3'd1;
         2'b01:   count_nxt = count - 3'd1;
         default: count_nxt = count;
      endcase
   end

   // Pointers and count; 2-bit pointers wrap 3 -> 0 naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         count  <= 3'd0;
      end else begin
         if (wr_fire) wr_ptr <= wr_ptr + 2'd1;
         if (rd_fire) rd_ptr <= rd_ptr + 2'd1;
         count <= count_nxt;
      end
   end

`ifdef FIFO_ERR_EN
   logic multi_hot;
   logic bad_read;

   assign multi_hot = (read_en & (read_en - 5'd1)) != 5'd0;
   assign bad_read  = ((read_en != 5'd0) && empty) || multi_hot;

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err <= 1'b0;
      end else if (bad_read) begin
         err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_input_fifo_rx.sv
// Bench for input_fifo_rx: a queue-based reference model checked every cycle,
// plus directed sequences with literal expectations. Build with FIFO_ERR_EN
// defined to also check the err output.
module tb_input_fifo_rx;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] rx;
   logic          drts;
   logic [4:0]    read_en;
   logic          cts;
   logic [DW-1:0] data_out;
   logic          empty;
   logic          full;
`ifdef FIFO_ERR_EN
   logic          err;
`endif

   int checks   = 0;
   int failures = 0;

   // reference model state
   logic [DW-1:0] exp_q[$];
   logic          m_cts = 1'b0;
   logic          m_err = 1'b0;

   input_fifo_rx #(.DATA_WIDTH(DW), .DEPTH(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .RX       (rx),
      .DRTS     (drts),
      .read_en  (read_en),
      .CTS      (cts),
      .Data_out (data_out),
      .empty    (empty),
      .full     (full)
`ifdef FIFO_ERR_EN
      ,
      .err      (err)
`endif
   );

   // clock
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: FIFO as a queue, grant rule from occupancy before the edge
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q.delete();
         m_cts = 1'b0;
         m_err = 1'b0;
      end else begin
         int  sz;
         logic do_rd;
         logic do_wr;
         sz    = exp_q.size();
         do_rd = (read_en != 5'd0) && (sz > 0);
         do_wr = m_cts && drts;
         if ((read_en != 5'd0) && ((sz == 0) || ($countones(read_en) > 1))) m_err = 1'b1;
         if (do_rd) void'(exp_q.pop_front());
         if (do_wr) exp_q.push_back(rx);
         m_cts = !m_cts && drts && (sz < 4);
      end
   end

   // compare process: every negedge outside reset
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         chk("m_cts", cts, m_cts);
         chk("m_empty", empty, exp_q.size() == 0);
         chk("m_full", full, exp_q.size() == 4);
         if (exp_q.size() > 0) chk("m_data", data_out, exp_q[0]);
`ifdef FIFO_ERR_EN
         chk("m_err", err, m_err);
`endif
      end
   end

   // driver: offer one flit, wait for CTS (bounded), keep DRTS through the write edge
   task automatic send(input logic [DW-1:0] v, output int waited);
      logic ok;
      ok     = 1'b0;
      waited = -1;
      rx     = v;
      drts   = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (cts) begin
            ok     = 1'b1;
            waited = i;
            break;
         end
      end
      if (!ok) chk("send_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      drts = 1'b0;
   endtask

   // driver: check head then pop it with the given strobe pattern
   task automatic read_one(input logic [DW-1:0] v, input logic [4:0] bits);
      @(negedge clk);
      chk("rd_head", data_out, v);
      chk("rd_nonempty", empty, 1'b0);
      read_en = bits;
      @(posedge clk); #1;
      read_en = 5'd0;
   endtask

   initial begin
      int w;
      int pulses;
      int pulse_cyc[8];
      logic seen;
      logic [DW-1:0] nxt;

      rst = 1'b1; rx = '0; drts = 1'b0; read_en = 5'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_cts", cts, 1'b0);
      chk("reset_empty", empty, 1'b1);
      chk("reset_full", full, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;

      // first flit: grant in cycle 1, falls through immediately
      send(32'hA5A5A5A5, w);
      chk("first_grant_cycle", w, 1);
      @(negedge clk);
      chk("first_data", data_out, 32'hA5A5A5A5);
      chk("first_empty", empty, 1'b0);
      chk("model_size_1", exp_q.size(), 1);
      @(posedge clk); #1;
      read_one(32'hA5A5A5A5, 5'b00001);

      // DRTS held with 1..5, no reads: four grants two cycles apart, then full
      drts = 1'b1; rx = 32'd1; nxt = 32'd2; pulses = 0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         seen = cts;
         if (seen && pulses < 8) begin
            pulse_cyc[pulses] = c;
            pulses++;
         end
         @(posedge clk); #1;
         if (seen) begin
            rx  = nxt;
            nxt = nxt + 1;
         end
      end
      chk("pulse_count", pulses, 4);
      chk("pulse0_cycle", pulse_cyc[0], 1);
      for (int k = 1; k < 4; k++) chk("pulse_gap", pulse_cyc[k] - pulse_cyc[k-1], 2);
      @(negedge clk);
      chk("full_after_4", full, 1'b1);
      chk("full_head", data_out, 32'd1);
      chk("full_no_cts", cts, 1'b0);
      chk("model_size_4", exp_q.size(), 4);
      @(posedge clk); #1;

      // single read from full frees a slot; held DRTS then writes 5
      read_en = 5'b00001;
      @(posedge clk); #1;
      read_en = 5'd0;
      @(negedge clk);
      chk("after_read_full", full, 1'b0);
      chk("after_read_head", data_out, 32'd2);
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) @(negedge clk);
         if (cts) begin
            seen = 1'b1;
            break;
         end
      end
      chk("regrant_seen", seen, 1'b1);
      @(posedge clk); #1;
      drts = 1'b0;
      @(negedge clk);
      chk("refull", full, 1'b1);
      @(posedge clk); #1;
      read_one(32'd2, 5'b00010);
      read_one(32'd3, 5'b00100);

      // count=2: simultaneous write of 0x10 and read
      rx = 32'h10; drts = 1'b1; seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (cts) begin
            seen = 1'b1;
            break;
         end
      end
      chk("simul_grant", seen, 1'b1);
      read_en = 5'b10000;
      @(posedge clk); #1;
      read_en = 5'd0; drts = 1'b0;
      @(negedge clk);
      chk("simul_head", data_out, 32'd5);
      chk("simul_full", full, 1'b0);
      chk("model_size_2", exp_q.size(), 2);
      @(posedge clk); #1;
      read_one(32'd5, 5'b01000);
      read_one(32'h10, 5'b00001);
      @(negedge clk);
      chk("drained_empty", empty, 1'b1);
      @(posedge clk); #1;

      // read while empty is ignored (and flagged when err exists)
      read_en = 5'b00001;
      @(posedge clk); #1;
      read_en = 5'd0;
      @(negedge clk);
      chk("empty_read_ignored", empty, 1'b1);
`ifdef FIFO_ERR_EN
      chk("err_empty_read", err, 1'b1);
      repeat (3) @(negedge clk);
      chk("err_sticky", err, 1'b1);
`endif
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
`ifdef FIFO_ERR_EN
      chk("err_cleared", err, 1'b0);
`endif
      chk("rst_empty", empty, 1'b1);
      @(posedge clk); #1;
      rst = 1'b0;

      // six fill/drain rounds, values 0..23, pointers wrap repeatedly
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 4; i++) send(DW'(r*4 + i), w);
         @(negedge clk);
         chk("round_full", full, 1'b1);
         @(posedge clk); #1;
         for (int i = 0; i < 4; i++) read_one(DW'(r*4 + i), 5'(1 << (i % 5)));
      end
      @(negedge clk);
      chk("rounds_empty", empty, 1'b1);
      @(posedge clk); #1;

      // two strobes at once still pops one entry (flagged when err exists)
      send(32'h77, w);
      send(32'h78, w);
      read_one(32'h77, 5'b00011);
      @(negedge clk);
      chk("multi_hot_head", data_out, 32'h78);
`ifdef FIFO_ERR_EN
      chk("err_multi_hot", err, 1'b1);
`endif
      @(posedge clk); #1;
      read_one(32'h78, 5'b00001);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;

      // reset during GRANT aborts the handshake without writing
      rx = 32'h99; drts = 1'b1; seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (cts) begin
            seen = 1'b1;
            break;
         end
      end
      chk("abort_grant_seen", seen, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("abort_cts", cts, 1'b0);
      chk("abort_empty", empty, 1'b1);
      drts = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_no_write", empty, 1'b1);
      chk("abort_idle", cts, 1'b0);
      repeat (3) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/input_fifo_rx.md
INPUT_FIFO_RX -- requirements
Module: input_fifo_rx

Interface
- REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning flit width in bits.
- REQ-002 The block SHALL have parameter DEPTH, default 4, meaning FIFO entries; only 4 is supported and pointers are 2 bits.
- REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
- REQ-005 The block SHALL have port RX, input, DATA_WIDTH bits: incoming flit from the upstream sender.
- REQ-006 The block SHALL have port DRTS, input, 1 bit: upstream request-to-send, held high until CTS is seen.
- REQ-007 The block SHALL have port read_en, input, 5 bits: one-hot read strobes from the downstream arbiters, bit order N,E,W,S,L.
- REQ-008 The block SHALL have port CTS, output, 1 bit: registered clear-to-send returned upstream.
- REQ-009 The block SHALL have port Data_out, output, DATA_WIDTH bits: head-of-FIFO flit.
- REQ-010 The block SHALL have port empty, output, 1 bit: FIFO holds zero entries.
- REQ-011 The block SHALL have port full, output, 1 bit: FIFO holds DEPTH entries.

Function
- REQ-012 The block SHALL implement a two-state handshake register CTS with states IDLE (CTS=0) and GRANT (CTS=1).
- REQ-013 In IDLE, the block SHALL move to GRANT on the next edge iff DRTS=1 and full=0; otherwise it SHALL stay in IDLE.
- REQ-014 In GRANT, the block SHALL return to IDLE on the next edge unconditionally, so CTS is a single-cycle pulse.
- REQ-015 The block SHALL write RX into mem[wr_ptr] and increment wr_ptr modulo 4 on the edge ending a cycle with CTS=1 and DRTS=1.
- REQ-016 A cycle with CTS=1 and DRTS=0 SHALL NOT write.
- REQ-017 The block SHALL treat a read as a cycle with read_en != 0 and empty=0; on that edge it SHALL increment rd_ptr modulo 4.
- REQ-018 A read while empty SHALL be ignored, with pointers unchanged.
- REQ-019 Data_out SHALL equal mem[rd_ptr] combinationally (first-word fall-through), so read latency is 0 cycles from write-edge plus one.
- REQ-020 The block SHALL keep a 3-bit count of 0..4.
- REQ-021 A write alone SHALL increment count, a read alone SHALL decrement it, and a simultaneous read and write SHALL leave it unchanged.
- REQ-022 empty SHALL equal (count==0) and full SHALL equal (count==4).
- REQ-023 Pointer wrap SHALL be 3->0.
- REQ-024 A simultaneous read and write at count=4 SHALL NOT occur, because CTS is never granted while full; the same cycle read and write SHALL be legal at every other count, including 0 with write only.
- REQ-025 DRTS held high after a write SHALL cause a new grant two cycles after the previous grant, provided the FIFO is not full.

Reset
- REQ-026 On rst=1, asynchronously: CTS=0 (IDLE), wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0.
- REQ-027 mem contents SHALL NOT be reset, and Data_out SHALL be don't-care while empty.
- REQ-028 An assertion of rst during GRANT SHALL abort the handshake with no write.

Configuration
- REQ-029 Macro FIFO_ERR_EN SHALL be defined to add output err, 1 bit, sticky high.
- REQ-030 With FIFO_ERR_EN, err SHALL be set on the edge after any cycle where read_en != 0 with empty=1, or where read_en has more than one bit set; err SHALL be cleared only by rst.
- REQ-031 Without FIFO_ERR_EN, the err port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
- REQ-032 Reset, then DRTS=1 with RX=0xA5A5A5A5 -> CTS=1 in cycle 1, count=1, Data_out=0xA5A5A5A5, empty=0.
- REQ-033 DRTS held high with RX=1,2,3,4,5 and no reads -> 4 CTS pulses two cycles apart, full=1, no fifth CTS, and Data_out=1.
- REQ-034 From full, pulse read_en=5'b00001 once -> count=3, Data_out=2, and the held DRTS gets CTS on the next eligible cycle, writing 5.
- REQ-035 count=2 with simultaneous write (RX=0x10) and read_en=5'b10000 -> count stays 2, rd_ptr and wr_ptr both advance, and 0x10 is read after the older entry.
- REQ-036 Fill/drain 6 times (24 flits, values 0..23) -> output order 0..23 with pointer wrap, and empty=1 at the end.
- REQ-037 With FIFO_ERR_EN: read_en=5'b00011 or a read when empty -> err=1 next cycle and held until rst; rst mid-GRANT -> CTS=0 immediately and count=0.
